// File: rtl/alu_pkg.sv
// Shared ALU definitions: command codes, datapath widths and the arbiter FSM encoding.
package alu_pkg;

  localparam int OPW  = 8;
  localparam int RESW = 16;

  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_INC  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_DEC  = 4'd3;
  localparam logic [3:0] CMD_MUL  = 4'd4;
  localparam logic [3:0] CMD_DIV  = 4'd5;
  localparam logic [3:0] CMD_SHL  = 4'd6;
  localparam logic [3:0] CMD_SHR  = 4'd7;
  localparam logic [3:0] CMD_AND  = 4'd8;
  localparam logic [3:0] CMD_OR   = 4'd9;
  localparam logic [3:0] CMD_INV  = 4'd10;
  localparam logic [3:0] CMD_NAND = 4'd11;
  localparam logic [3:0] CMD_NOR  = 4'd12;
  localparam logic [3:0] CMD_XOR  = 4'd13;
  localparam logic [3:0] CMD_XNOR = 4'd14;
  localparam logic [3:0] CMD_BUF  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU with 16-bit result; output is zero while en is low.
module alu
  import alu_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [3:0]      cmd,
  input  logic            en,
  output logic [RESW-1:0] y
);

  logic [RESW-1:0] ax_s;
  logic [RESW-1:0] bx_s;
  logic [RESW-1:0] res_s;

  assign ax_s = {8'd0, a};
  assign bx_s = {8'd0, b};

  // Command decode; shifts use b[2:0], divide by zero returns all ones.
  always_comb begin
    res_s = 16'd0;
    case (cmd)
      CMD_ADD:  res_s = ax_s + bx_s;
      CMD_INC:  res_s = ax_s + 16'd1;
      CMD_SUB:  res_s = ax_s - bx_s;
      CMD_DEC:  res_s = ax_s - 16'd1;
      CMD_MUL:  res_s = ax_s * bx_s;
      CMD_DIV:  res_s = (b == 8'd0) ? 16'hFFFF : (ax_s / bx_s);
      CMD_SHL:  res_s = ax_s << b[2:0];
      CMD_SHR:  res_s = ax_s >> b[2:0];
      CMD_AND:  res_s = {8'd0, a & b};
      CMD_OR:   res_s = {8'd0, a | b};
      CMD_INV:  res_s = {8'd0, ~a};
      CMD_NAND: res_s = {8'd0, ~(a & b)};
      CMD_NOR:  res_s = {8'd0, ~(a | b)};
      CMD_XOR:  res_s = {8'd0, a ^ b};
      CMD_XNOR: res_s = {8'd0, ~(a ^ b)};
      CMD_BUF:  res_s = ax_s;
      default:  res_s = 16'd0;
    endcase
    if (en) y = res_s;
    else    y = 16'd0;
  end

endmodule

// File: rtl/alu_arb_picker.sv
// Grant selection for alu_arbiter. ALU_ARB_RR_EN enables round-robin search from ptr+1;
// otherwise (and when mode is low) the lowest asserted index wins.
module alu_arb_picker
  import alu_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [GW-1:0]   ptr,
  input  logic            mode,
  output logic [NREQ-1:0] grant,
  output logic [GW-1:0]   idx,
  output logic            any
);

  logic          found_s;
  logic [GW-1:0] j_s;

`ifndef ALU_ARB_RR_EN
  logic unused_s;
  assign unused_s = ^{ptr, mode};
`endif

  assign any = |valid;

  // Priority search; the last hit in the descending loop is the lowest index.
  always_comb begin
    found_s = 1'b0;
    idx     = '0;
    j_s     = '0;
    grant   = '0;
`ifdef ALU_ARB_RR_EN
    if (mode) begin
      for (int k = 1; k <= NREQ; k++) begin
        j_s     = GW'((int'(ptr) + k) % NREQ);
        idx     = (!found_s && valid[j_s]) ? j_s : idx;
        found_s = found_s | valid[j_s];
      end
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        j_s     = GW'(k);
        idx     = valid[j_s] ? j_s : idx;
        found_s = found_s | valid[j_s];
      end
    end
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      j_s     = GW'(k);
      idx     = valid[j_s] ? j_s : idx;
      found_s = found_s | valid[j_s];
    end
`endif
    if (found_s) grant[idx] = 1'b1;
    else         grant      = '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu among NREQ requesters: IDLE grant, EXEC compute, RESP hold.
// Define ALU_ARB_RR_EN for round-robin grants; default is fixed priority (lowest index).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_a,
  input  logic [NREQ*OPW-1:0]  req_b,
  input  logic [NREQ*4-1:0]    req_cmd,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [RESW-1:0]      rsp_y,
  output logic [OPW-1:0]       alu_a,
  output logic [OPW-1:0]       alu_b,
  output logic [3:0]           alu_cmd,
  output logic                 alu_en,
  input  logic [RESW-1:0]      alu_y,
  output logic                 busy
);

  arb_state_e      state_r, state_n;
  logic [GW-1:0]   grant_r;
  logic [OPW-1:0]  a_r, b_r;
  logic [3:0]      cmd_r;
  logic [RESW-1:0] y_r;
  logic [GW-1:0]   ptr_s;
  logic            mode_s;
  logic [NREQ-1:0] pick_grant_s;
  logic [GW-1:0]   pick_idx_s;
  logic            pick_any_s;
  logic [OPW-1:0]  a_arr_s   [NREQ];
  logic [OPW-1:0]  b_arr_s   [NREQ];
  logic [3:0]      cmd_arr_s [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_arr_s[i]   = req_a[i*OPW +: OPW];
    assign b_arr_s[i]   = req_b[i*OPW +: OPW];
    assign cmd_arr_s[i] = req_cmd[i*4 +: 4];
  end

`ifdef ALU_ARB_RR_EN
  logic [GW-1:0] ptr_r;

  // Round-robin pointer follows each grant; reset value makes requester 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              ptr_r <= GW'(NREQ - 1);
    else if (state_r == ST_IDLE && pick_any_s) ptr_r <= pick_idx_s;
    else                                     ptr_r <= ptr_r;
  end
  assign ptr_s  = ptr_r;
  assign mode_s = 1'b1;
`else
  assign ptr_s  = GW'(NREQ - 1);
  assign mode_s = 1'b0;
`endif

  alu_arb_picker #(.NREQ(NREQ)) u_picker (
    .valid (req_valid),
    .ptr   (ptr_s),
    .mode  (mode_s),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: state_n = pick_any_s ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_n = ST_RESP;
      ST_RESP: state_n = rsp_ready[grant_r] ? ST_IDLE : ST_RESP;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, operand capture on grant, result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      a_r     <= 8'd0;
      b_r     <= 8'd0;
      cmd_r   <= 4'd0;
      y_r     <= 16'd0;
    end else begin
      state_r <= state_n;
      if (state_r == ST_IDLE && pick_any_s) begin
        grant_r <= pick_idx_s;
        a_r     <= a_arr_s[pick_idx_s];
        b_r     <= b_arr_s[pick_idx_s];
        cmd_r   <= cmd_arr_s[pick_idx_s];
      end else begin
        grant_r <= grant_r;
        a_r     <= a_r;
        b_r     <= b_r;
        cmd_r   <= cmd_r;
      end
      if (state_r == ST_EXEC) y_r <= alu_y;
      else                    y_r <= y_r;
    end
  end

  // Handshake decode; req_ready is forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_r == ST_IDLE && rst_n) req_ready = pick_grant_s;
    else                             req_ready = '0;
    if (state_r == ST_RESP) rsp_valid[grant_r] = 1'b1;
    else                    rsp_valid          = '0;
  end

  assign alu_a   = a_r;
  assign alu_b   = b_r;
  assign alu_cmd = cmd_r;
  assign alu_en  = (state_r == ST_EXEC);
  assign busy    = (state_r != ST_IDLE);
  assign rsp_y   = y_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter + alu: directed cases plus random traffic checked
// every cycle against a transaction-level model (honours ALU_ARB_RR_EN).
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'd0, req_ready, rsp_valid, rsp_ready = 4'd0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0;
  logic [15:0] req_cmd = 16'd0;
  logic [15:0] rsp_y, alu_y;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_en, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_y(rsp_y), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cmd(alu_cmd), .alu_en(alu_en), .alu_y(alu_y), .busy(busy)
  );

  alu u_alu (.a(alu_a), .b(alu_b), .cmd(alu_cmd), .en(alu_en), .y(alu_y));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] c);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (c)
      4'd0:  r = ia + ib;
      4'd1:  r = ia + 1;
      4'd2:  r = ia - ib;
      4'd3:  r = ia - 1;
      4'd4:  r = ia * ib;
      4'd5:  r = (ib == 0) ? 65535 : ia / ib;
      4'd6:  r = ia * (1 << (ib % 8));
      4'd7:  r = ia / (1 << (ib % 8));
      4'd8:  r = ia & ib;
      4'd9:  r = ia | ib;
      4'd10: r = 255 - ia;
      4'd11: r = 255 - (ia & ib);
      4'd12: r = 255 - (ia | ib);
      4'd13: r = ia ^ ib;
      4'd14: r = 255 - (ia ^ ib);
      default: r = ia;
    endcase
    return 16'(r);
  endfunction

  // Transaction-level model: one op in flight, aged in cycles since acceptance.
  bit         m_active;
  int         m_age, m_owner, m_last;
  logic [7:0] m_a, m_b;
  logic [3:0] m_cmd;
  logic [15:0] m_y;

  function automatic int model_pick(input logic [3:0] v);
`ifdef ALU_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++)
      if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++)
      if (v[k]) return k;
`endif
    return -1;
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    logic [3:0] e_rr, e_rv;
    int g;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0); chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_y", rsp_y, 0);         chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);         chk("rst_alu_cmd", alu_cmd, 0);
      chk("rst_alu_en", alu_en, 0);       chk("rst_busy", busy, 0);
      m_active = 0; m_age = 0; m_owner = 0; m_last = NREQ - 1;
      m_a = 0; m_b = 0; m_cmd = 0; m_y = 0;
    end else begin
      g    = m_active ? -1 : model_pick(req_valid);
      e_rr = (g >= 0) ? 4'(1 << g) : 4'd0;
      e_rv = (m_active && m_age >= 1) ? 4'(1 << m_owner) : 4'd0;
      chk("req_ready", req_ready, e_rr);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_y", rsp_y, m_y);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_cmd", alu_cmd, m_cmd);
      chk("alu_en", alu_en, (m_active && m_age == 0) ? 1 : 0);
      chk("busy", busy, m_active ? 1 : 0);
      if (g >= 0) begin
        m_active = 1; m_age = 0; m_owner = g; m_last = g;
        m_a = req_a[g*8 +: 8]; m_b = req_b[g*8 +: 8]; m_cmd = req_cmd[g*4 +: 4];
      end else if (m_active && m_age == 0) begin
        m_age = 1;
        m_y   = alu_model(m_a, m_b, m_cmd);
      end else if (m_active && rsp_ready[m_owner]) begin
        m_active = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] c);
    req_valid[i]     = v;
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_cmd[i*4 +: 4] = c;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) return;
      tick();
    end
    chk({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int got[$];
    int exp_order[$];
    logic [3:0] acc;
    logic [15:0] held;

    chk("pin_add", alu_model(8'd25, 8'd17, CMD_ADD), 16'd42);
    chk("pin_mul", alu_model(8'd15, 8'd15, CMD_MUL), 16'h00E1);
    chk("pin_sub", alu_model(8'd3, 8'd5, CMD_SUB), 16'hFFFE);

    repeat (3) @(negedge clk);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_y", rsp_y, 0);
    tick();

    // single ADD from requester 2
    rsp_ready = 4'hF;
    set_req(2, 1'b1, 8'd25, 8'd17, CMD_ADD);
    @(negedge clk); chk("add_ready", req_ready, 4'b0100);
    tick(); set_req(2, 1'b0, 8'd25, 8'd17, CMD_ADD);
    @(negedge clk); chk("add_en", alu_en, 1); chk("add_noresp", rsp_valid, 0);
    tick();
    @(negedge clk); chk("add_rsp_valid", rsp_valid, 4'b0100); chk("add_y", rsp_y, 16'd42);
    chk("add_busy", busy, 1);
    tick();
    @(negedge clk); chk("add_busy_drop", busy, 0);
    tick();

    // MUL from requester 1
    set_req(1, 1'b1, 8'd15, 8'd15, CMD_MUL);
    @(negedge clk); chk("mul_ready", req_ready, 4'b0010);
    tick(); set_req(1, 1'b0, 8'd15, 8'd15, CMD_MUL);
    tick();
    @(negedge clk); chk("mul_y", rsp_y, 16'h00E1);
    wait_idle("mul");
    tick();

    // contended grant order from a fresh reset
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(i + 1), 8'd2, CMD_SHL);
`ifdef ALU_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0};
`endif
    for (int k = 0; k < 40 && got.size() < exp_order.size(); k++) begin
      @(negedge clk);
      if (req_ready != 4'd0) got.push_back(oh2i(req_ready));
      tick();
    end
    chk("order_count", got.size(), exp_order.size());
    for (int k = 0; k < exp_order.size() && k < got.size(); k++)
      chk($sformatf("order_%0d", k), got[k], exp_order[k]);
    req_valid = 4'd0;
    wait_idle("order");
    tick();

    // backpressure on requester 1 while requester 3 waits
    rsp_ready = 4'd0;
    set_req(1, 1'b1, 8'h30, 8'h07, CMD_SUB);
    @(negedge clk); chk("bp_ready", req_ready, 4'b0010);
    tick(); set_req(1, 1'b0, 8'h30, 8'h07, CMD_SUB);
    set_req(3, 1'b1, 8'h09, 8'h03, CMD_XOR);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 4'b0010);
      chk("bp_rsp_y", rsp_y, 16'h0029);
      chk("bp_no_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 4'hF;
    @(negedge clk); chk("bp_hs_no_ready", req_ready, 0);
    tick();
    @(negedge clk); chk("bp_next_ready", req_ready, 4'b1000);
    tick(); set_req(3, 1'b0, 8'h09, 8'h03, CMD_XOR);
    wait_idle("bp");
    tick();

    // asynchronous reset during EXEC
    set_req(2, 1'b1, 8'h44, 8'h55, CMD_OR);
    @(negedge clk);
    tick(); set_req(2, 1'b0, 8'h44, 8'h55, CMD_OR);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_req_ready", req_ready, 0); chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_rsp_y", rsp_y, 0);         chk("ar_alu_a", alu_a, 0);
    chk("ar_alu_b", alu_b, 0);         chk("ar_alu_cmd", alu_cmd, 0);
    chk("ar_alu_en", alu_en, 0);       chk("ar_busy", busy, 0);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(16 + i), 8'd1, CMD_ADD);
    tick();
    rst_n = 1'b1;
    @(negedge clk); chk("ar_first_grant", req_ready, 4'b0001); chk("ar_no_rsp", rsp_valid, 0);
    tick();
    req_valid = 4'd0;
    wait_idle("ar");
    tick();

    // requester 0 withdraws while requester 1 is served
    set_req(1, 1'b1, 8'h11, 8'h22, CMD_ADD);
    @(negedge clk); chk("drop_ready1", req_ready, 4'b0010);
    tick(); set_req(1, 1'b0, 8'h11, 8'h22, CMD_ADD);
    set_req(0, 1'b1, 8'hAA, 8'hBB, CMD_AND);
    set_req(3, 1'b1, 8'h05, 8'h06, CMD_OR);
    tick(); set_req(0, 1'b0, 8'hAA, 8'hBB, CMD_AND);
    @(negedge clk); chk("drop_rsp1", rsp_valid, 4'b0010);
    tick();
    @(negedge clk); chk("drop_grant3", req_ready, 4'b1000);
    tick(); set_req(3, 1'b0, 8'h05, 8'h06, CMD_OR);
    @(negedge clk); chk("drop_alu_a", alu_a, 8'h05);
    wait_idle("drop");
    tick();

    // random traffic honouring the hold-until-ready rule
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      if (cyc % 700 == 350) rst_n = 1'b0;
      else rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && acc[i])
          set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'($urandom));
        else if (req_valid[i])
          req_valid[i] = ($urandom_range(0, 15) != 0);
        else if ($urandom_range(0, 2) == 0)
          set_req(i, 1'b1, 8'($urandom), 8'($urandom), 4'($urandom));
      end
      rsp_ready = 4'($urandom) | 4'($urandom);
    end
    rst_n = 1'b1;
    req_valid = 4'd0;
    rsp_ready = 4'hF;
    wait_idle("final");
    held = rsp_y;
    @(negedge clk); chk("final_y_hold", rsp_y, held);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
